// File: rtl/la_pkt_decoder.sv
// ---------------------------------------------------------------------------
// la_pkt_decoder
//
// Decodes a logic-analyser capture stream into timestamped sample events.
// Each 32-bit beat is one of:
//   SAMPLE : tdata[31:24] != 0. The upper byte is a tick delta added to a
//            running 32-bit timestamp, and the lower 24 bits are sample data.
//   SYNC   : tdata == 0. Keep-alive beat; counted only.
//   OVF    : tdata[31:24] == 0, tdata[23:0] != 0. Capture overflow; counted
//            and flagged on the next emitted event through evt_gap.
// Beats are framed into packets of PKT_LEN with tlast on the final beat.
// A missing tlast sends the decoder into RESYNC, where beats are discarded
// until a tlast restores framing.
//
// Ports
//   axi_clk, axi_reset_n      : clock, asynchronous active-low reset
//   clr                       : synchronous clear of timestamp, counters, flags
//   s_tdata/s_tvalid/s_tlast/s_tready : capture stream input
//   evt_valid/evt_ready/evt_data/evt_time/evt_gap : decoded event output
//   sync_cnt, ovf_cnt, ferr_cnt, pkt_cnt : saturating status counters
//   resync                    : high while discarding beats to regain framing
// ---------------------------------------------------------------------------
module la_pkt_decoder #(
    parameter int PKT_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic             axi_clk,
    input  logic             axi_reset_n,
    input  logic             clr,
    input  logic [31:0]      s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [23:0]      evt_data,
    output logic [31:0]      evt_time,
    output logic             evt_gap,
    output logic [CNT_W-1:0] sync_cnt,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] ferr_cnt,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             resync
);

    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    typedef enum logic {
        ALIGNED = 1'b0,
        RESYNC  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] beat_idx;
    logic [31:0]      time_acc;
    logic             gap_pend;

    logic             vld_p1;
    logic [23:0]      data_p1;
    logic [31:0]      time_p1;
    logic             gap_p1;

    logic             accept_p0;
    logic             live_p0;
    logic             at_last_p0;
    logic             smp_p0;
    logic             sync_p0;
    logic             ovf_p0;
    logic             pkt_p0;
    logic             ferr_p0;

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Timestamp advance, modulo 2^32; wrap is a normal event.
    function automatic logic [31:0] time_add(input logic [31:0] t, input logic [7:0] n);
        return t + {24'd0, n};
    endfunction

    // ---- stage p0: beat acceptance and classification ----
    // The single output register frees up in the same cycle it is consumed,
    // so the stream can run at one beat per cycle.
    assign s_tready   = !vld_p1 || evt_ready;
    assign accept_p0  = s_tvalid && s_tready;
    // A beat accepted alongside clr is dropped; RESYNC beats are discarded.
    assign live_p0    = accept_p0 && !clr && (state == ALIGNED);
    assign at_last_p0 = (beat_idx == LAST_IDX);
    assign smp_p0     = live_p0 && (s_tdata[31:24] != 8'd0);
    assign sync_p0    = live_p0 && (s_tdata == 32'd0);
    assign ovf_p0     = live_p0 && (s_tdata[31:24] == 8'd0) && (s_tdata[23:0] != 24'd0);
    assign pkt_p0     = live_p0 && s_tlast && at_last_p0;
    // Framing error: tlast early, or the final beat arrived without tlast.
    assign ferr_p0    = live_p0 && (s_tlast != at_last_p0);

    // Framing FSM: state register
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state <= ALIGNED;
        end else begin
            state <= state_nxt;
        end
    end

    // Framing FSM: next state
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ALIGNED;
        end else if (accept_p0) begin
            case (state)
                ALIGNED: if (!s_tlast && at_last_p0) state_nxt = RESYNC;
                RESYNC:  if (s_tlast) state_nxt = ALIGNED;
                default: state_nxt = ALIGNED;
            endcase
        end
    end

    // Framing FSM: outputs
    always_comb begin
        resync = (state == RESYNC);
    end

    // Beat position, running timestamp and pending-gap flag. beat_idx is
    // zeroed on entry to RESYNC, so leaving RESYNC finds it already at 0.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            beat_idx <= '0;
            time_acc <= '0;
            gap_pend <= 1'b0;
        end else if (clr) begin
            beat_idx <= '0;
            time_acc <= '0;
            gap_pend <= 1'b0;
        end else begin
            if (live_p0) begin
                beat_idx <= (s_tlast || at_last_p0) ? '0 : beat_idx + 1'b1;
            end
            if (smp_p0) begin
                time_acc <= time_add(time_acc, s_tdata[31:24]);
                gap_pend <= 1'b0;
            end else if (ovf_p0) begin
                gap_pend <= 1'b1;
            end
        end
    end

    // ---- stage p1: registered event output ----
    // clr leaves a pending event alone; it is held until its handshake.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            time_p1 <= '0;
            gap_p1  <= 1'b0;
        end else if (smp_p0) begin
            vld_p1  <= 1'b1;
            data_p1 <= s_tdata[23:0];
            time_p1 <= time_add(time_acc, s_tdata[31:24]);
            gap_p1  <= gap_pend;
        end else if (evt_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign evt_valid = vld_p1;
    assign evt_data  = data_p1;
    assign evt_time  = time_p1;
    assign evt_gap   = gap_p1;

    // Status counters
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            sync_cnt <= '0;
            ovf_cnt  <= '0;
            ferr_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (clr) begin
            sync_cnt <= '0;
            ovf_cnt  <= '0;
            ferr_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (sync_p0) sync_cnt <= sat_inc(sync_cnt);
            if (ovf_p0)  ovf_cnt  <= sat_inc(ovf_cnt);
            if (ferr_p0) ferr_cnt <= sat_inc(ferr_cnt);
            if (pkt_p0)  pkt_cnt  <= sat_inc(pkt_cnt);
        end
    end

endmodule

// File: doc/la_pkt_decoder.md
LA_PKT_DECODER -- requirements
Module: la_pkt_decoder

Interface
REQ-001 SHALL have parameter PKT_LEN, default 8, giving the expected beats per capture packet, with tlast on the final beat.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of each status counter.
REQ-003 SHALL have port: axi_clk  in  1  clock; all logic is in this domain.
REQ-004 SHALL have port: axi_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: clr  in  1  synchronous clear pulse for timestamp, counters and flags.
REQ-006 SHALL have ports: s_tdata in 32, s_tvalid in 1, s_tlast in 1, s_tready out 1; these form the capture stream input.
REQ-007 SHALL have ports: evt_valid out 1, evt_ready in 1, evt_data out 24, evt_time out 32, evt_gap out 1; these form the decoded-event output.
REQ-008 SHALL have ports: sync_cnt, ovf_cnt, ferr_cnt, pkt_cnt, each out CNT_W; these are the status counters.
REQ-009 SHALL have port: resync out 1, high while discarding beats to regain framing.

Function
REQ-010 SHALL accept a beat when s_tvalid && s_tready, with s_tready = !evt_valid || evt_ready (single-entry output register, no combinational path from s_tdata to outputs).
REQ-011 SHALL classify each accepted beat as follows:
- SAMPLE: tdata[31:24] != 0.
- SYNC: tdata == 0.
- OVF: tdata[31:24] == 0 and tdata[23:0] != 0.
REQ-012 SHALL, on SAMPLE in state ALIGNED:
- set time_acc = time_acc + tdata[31:24], modulo 2^32;
- load evt_data = tdata[23:0] and evt_time = the new time_acc;
- set evt_valid = 1 on the cycle after acceptance (latency 1).
REQ-013 SHALL, on SYNC, emit no event, leave time_acc unchanged and increment sync_cnt.
REQ-014 SHALL, on OVF, emit no event, increment ovf_cnt, set gap_pend = 1 and leave time_acc unchanged.
REQ-015 SHALL copy gap_pend into evt_gap for the next emitted event, then clear gap_pend in the same cycle.
- An OVF arriving in the same cycle as that event's acceptance is impossible (one beat per cycle).
REQ-016 SHALL hold evt_valid, evt_data, evt_time and evt_gap stable while evt_valid && !evt_ready.
- evt_valid drops the cycle after the handshake unless a new SAMPLE is accepted that same cycle (back-to-back at full rate).
REQ-017 SHALL track beat_idx, ranging 0..PKT_LEN-1, advanced on every accepted beat in ALIGNED.
REQ-018 SHALL implement FSM states ALIGNED (reset state) and RESYNC with these transitions:
- ALIGNED, tlast at beat_idx == PKT_LEN-1: pkt_cnt++, beat_idx <= 0, stay ALIGNED.
- ALIGNED, tlast at beat_idx < PKT_LEN-1 (early end): beat is still decoded, ferr_cnt++, beat_idx <= 0, stay ALIGNED.
- ALIGNED, beat_idx == PKT_LEN-1 without tlast: beat is still decoded, ferr_cnt++, go to RESYNC.
- RESYNC: beats are accepted and discarded with no decode and no counters changed; a beat with tlast returns to ALIGNED with beat_idx <= 0.
REQ-019 SHALL keep resync = 1 exactly while in RESYNC.
REQ-020 SHALL saturate every status counter at 2^CNT_W-1; no wrap.
REQ-021 SHALL, on clr, zero time_acc, all counters and gap_pend, and force ALIGNED with beat_idx 0.
- A beat accepted in the clr cycle is ignored.
- A pending event stays until its handshake completes.
REQ-022 SHALL define time_acc wrap from 0xFFFFFFFF to a low value as normal; no flag is raised.

Reset
REQ-023 SHALL, while axi_reset_n is low, force s_tready=1 and evt_valid=0, and zero evt_data, evt_time, evt_gap, all counters, time_acc, gap_pend and beat_idx; state = ALIGNED.
REQ-024 SHALL, when reset asserts mid-packet, drop the partial packet and any pending event; after release, the next beat is treated as beat 0.

Verification
REQ-025 SHALL cover: one 8-beat packet {0x05_000001, 0x03_000002, 0x00000000, 0x01_000004 ... 0xFF_000004 with tlast}, evt_ready=1 -> events with times 5, 8, 9, ...; sync_cnt=1, pkt_cnt=1, ferr_cnt=0.
REQ-026 SHALL cover: OVF beat 0x00_000020 followed by SAMPLE 0x02_00ABCD -> ovf_cnt=1, event data 0x00ABCD with evt_gap=1; the following event has evt_gap=0.
REQ-027 SHALL cover: evt_ready held low for 10 cycles with continuous s_tvalid -> s_tready=0 after the first event, evt_* stable, no beat lost; on release, events stream one per cycle.
REQ-028 SHALL cover: tlast on beat 3 -> ferr_cnt=1 and the next beat is beat 0; a 10-beat packet with no tlast on beat 7 -> ferr_cnt=1, resync=1, beats 8-9 discarded, ALIGNED after tlast.
REQ-029 SHALL cover: time_acc preloaded near wrap (0xFFFFFFFE) then SAMPLE count 5 -> evt_time=0x00000003; clr mid-stream -> counters 0 and the next event time equals its own count.
REQ-030 SHALL cover: ferr_cnt driven to 0xFFFF then one more error -> ferr_cnt stays 0xFFFF; axi_reset_n low mid-packet -> all outputs at reset values within the same cycle.
